// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - debouncer sample/repeat strobes plus key-event round-robin queue
// Define KEY_ARB_PRIO_EN to swap the round-robin for fixed lowest-index-first priority.
module key_event_arbiter #(
  parameter int KEYS_NUM   = 4,
  parameter int SMP_DIV    = 50000,
  parameter int REP_DIV    = 10,
  parameter int FIFO_DEPTH = 4,
  localparam int CODE_W    = $clog2(KEYS_NUM)
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic [KEYS_NUM-1:0] KEY_UP,
  input  logic [KEYS_NUM-1:0] KEY_EN,
  output logic                SMP_CE,
  output logic                REP_CE,
  output logic                EVT_VALID,
  output logic [CODE_W-1:0]   EVT_CODE,
  input  logic                EVT_RDY,
  output logic                ANY_HELD,
  output logic [7:0]          DROP_CNT
);

  localparam int SMP_W = $clog2(SMP_DIV);
  localparam int REP_W = (REP_DIV > 1) ? $clog2(REP_DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'(SMP_DIV - 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REP_DIV - 1);
  localparam logic [AW:0]       FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic                smp_ce_q, smp_ce_d;
  logic                rep_ce_q, rep_ce_d;
  logic                any_held_q, any_held_d;
  logic [KEYS_NUM-1:0] pend_q, pend_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [CODE_W-1:0]   mem_q [FIFO_DEPTH];
  logic [CODE_W-1:0]   mem_d [FIFO_DEPTH];

  logic                found;
  logic                grant;
  logic [CODE_W-1:0]   grant_idx;
  logic [KEYS_NUM-1:0] grant_vec;
  logic [KEYS_NUM-1:0] drop_vec;
  logic [8:0]          drop_add;
  logic [9:0]          drop_sum;
  logic                pop, can_push;

`ifndef KEY_ARB_PRIO_EN
  logic [CODE_W-1:0]   ptr_q, ptr_d;
  logic [CODE_W-1:0]   rr_idx;
  localparam logic [CODE_W-1:0] KEY_LAST = CODE_W'(KEYS_NUM - 1);
`endif

  // Strobes are registered so the first SMP_CE lands SMP_DIV cycles after reset.
  always_comb begin
    smp_cnt_d = (smp_cnt_q == SMP_LAST) ? '0 : smp_cnt_q + 1'b1;
    smp_ce_d  = (smp_cnt_q == SMP_LAST);
    rep_cnt_d = rep_cnt_q;
    if (smp_ce_d) begin
      rep_cnt_d = (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + 1'b1;
    end
    rep_ce_d   = smp_ce_d & (rep_cnt_q == REP_LAST);
    any_held_d = |KEY_EN;
  end

  assign pop      = (count_q != '0) & EVT_RDY;
  assign can_push = (count_q != FULL_CNT) | pop;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
`ifdef KEY_ARB_PRIO_EN
    for (int i = KEYS_NUM - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        found     = 1'b1;
        grant_idx = CODE_W'(i);
      end
    end
`else
    rr_idx = ptr_q;
    for (int i = 0; i < KEYS_NUM; i++) begin
      rr_idx = (rr_idx == KEY_LAST) ? '0 : rr_idx + 1'b1;
      if (!found && pend_q[rr_idx]) begin
        found     = 1'b1;
        grant_idx = rr_idx;
      end
    end
    ptr_d = ptr_q;
`endif
    grant     = found & can_push;
    grant_vec = grant ? (KEYS_NUM'(1) << grant_idx) : '0;
`ifndef KEY_ARB_PRIO_EN
    if (grant) ptr_d = grant_idx;
`endif
  end

  // A re-arrival on a still-pending key that was not granted this cycle is lost.
  always_comb begin
    pend_d   = (pend_q & ~grant_vec) | KEY_UP;
    drop_vec = KEY_UP & pend_q & ~grant_vec;
    drop_add = '0;
    for (int i = 0; i < KEYS_NUM; i++) begin
      drop_add = drop_add + 9'(drop_vec[i]);
    end
    drop_sum   = {2'b00, drop_cnt_q} + {1'b0, drop_add};
    drop_cnt_d = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (grant) begin
      mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({grant, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      smp_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      smp_ce_q   <= 1'b0;
      rep_ce_q   <= 1'b0;
      any_held_q <= 1'b0;
      pend_q     <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifndef KEY_ARB_PRIO_EN
      ptr_q      <= KEY_LAST;
`endif
    end else begin
      smp_cnt_q  <= smp_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      smp_ce_q   <= smp_ce_d;
      rep_ce_q   <= rep_ce_d;
      any_held_q <= any_held_d;
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
`ifndef KEY_ARB_PRIO_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign SMP_CE    = smp_ce_q;
  assign REP_CE    = rep_ce_q;
  assign ANY_HELD  = any_held_q;
  assign DROP_CNT  = drop_cnt_q;
  assign EVT_VALID = (count_q != '0);
  assign EVT_CODE  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb/tb_key_event_arbiter.sv - directed self-checking bench for key_event_arbiter
module tb_key_event_arbiter;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] KEY_UP;
  logic [3:0] KEY_EN;
  logic       EVT_RDY;
  logic       SMP_CE, REP_CE, EVT_VALID, ANY_HELD;
  logic [1:0] EVT_CODE;
  logic [7:0] DROP_CNT;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [3:0] seq4 [6];
  int         exp4 [6];

  key_event_arbiter #(
    .KEYS_NUM(4), .SMP_DIV(4), .REP_DIV(3), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .CLR(CLR), .KEY_UP(KEY_UP), .KEY_EN(KEY_EN),
    .SMP_CE(SMP_CE), .REP_CE(REP_CE), .EVT_VALID(EVT_VALID),
    .EVT_CODE(EVT_CODE), .EVT_RDY(EVT_RDY), .ANY_HELD(ANY_HELD),
    .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    CLR = 1'b1;
    step;
    CLR = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; KEY_UP = '0; KEY_EN = '0; EVT_RDY = 1'b0;
    seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp4 = '{0, 1, 2, 3, 0, 1};
    step; step;
    chk("rst_smp_ce", 32'(SMP_CE), 0);
    chk("rst_rep_ce", 32'(REP_CE), 0);
    chk("rst_valid", 32'(EVT_VALID), 0);
    chk("rst_any_held", 32'(ANY_HELD), 0);
    chk("rst_code", 32'(EVT_CODE), 0);
    chk("rst_drop", 32'(DROP_CNT), 0);
    CLR = 1'b0;

    // prescaler: SMP_CE every 4 cycles, REP_CE every 12
    for (int k = 1; k <= 24; k++) begin
      step;
      chk($sformatf("smp_ce_c%0d", k), 32'(SMP_CE), (k % 4 == 0) ? 1 : 0);
      chk($sformatf("rep_ce_c%0d", k), 32'(REP_CE), (k % 12 == 0) ? 1 : 0);
    end

    KEY_EN = 4'b0100; step;
    chk("any_held_1", 32'(ANY_HELD), 1);
    KEY_EN = 4'b0000; step;
    chk("any_held_0", 32'(ANY_HELD), 0);

    // single event, two-cycle latency
    EVT_RDY = 1'b1; KEY_UP = 4'b0001;
    step;
    KEY_UP = 4'b0000;
    chk("t2_valid_t", 32'(EVT_VALID), 0);
    step;
    chk("t2_valid_t1", 32'(EVT_VALID), 1);
    chk("t2_code", 32'(EVT_CODE), 0);
    step;
    chk("t2_valid_t2", 32'(EVT_VALID), 0);
    step;
    chk("t2_valid_t3", 32'(EVT_VALID), 0);
    chk("t2_drop", 32'(DROP_CNT), 0);

    // all four keys at once
    do_reset;
    EVT_RDY = 1'b1; KEY_UP = 4'b1111;
    step;
    KEY_UP = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("t3_valid_%0d", i), 32'(EVT_VALID), 1);
      chk($sformatf("t3_code_%0d", i), 32'(EVT_CODE), i);
    end
    step;
    chk("t3_empty", 32'(EVT_VALID), 0);
    chk("t3_drop", 32'(DROP_CNT), 0);

    // fill FIFO with consumer stalled, overflow into pend, then a real drop
    EVT_RDY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      KEY_UP = seq4[i];
      step;
    end
    KEY_UP = 4'b0000;
    chk("t4_valid", 32'(EVT_VALID), 1);
    chk("t4_code", 32'(EVT_CODE), 0);
    chk("t4_drop0", 32'(DROP_CNT), 0);
    step; step;
    chk("t4_hold_code", 32'(EVT_CODE), 0);
    chk("t4_hold_valid", 32'(EVT_VALID), 1);
    chk("t4_drop_stall", 32'(DROP_CNT), 0);
    KEY_UP = 4'b0001;
    step;
    KEY_UP = 4'b0000;
    chk("t4_drop1", 32'(DROP_CNT), 1);
    EVT_RDY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t4_dvalid_%0d", i), 32'(EVT_VALID), 1);
      chk($sformatf("t4_dcode_%0d", i), 32'(EVT_CODE), exp4[i]);
      step;
    end
    chk("t4_empty", 32'(EVT_VALID), 0);

    // two keys re-pending every cycle
    KEY_UP = 4'b0011;
    step; step;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_valid_%0d", i), 32'(EVT_VALID), 1);
`ifdef KEY_ARB_PRIO_EN
      chk($sformatf("t5_code_%0d", i), 32'(EVT_CODE), 0);
`else
      chk($sformatf("t5_code_%0d", i), 32'(EVT_CODE), i % 2);
`endif
      step;
    end
    repeat (300) step;
    chk("t5_drop_sat", 32'(DROP_CNT), 255);
    KEY_UP = 4'b0000;

    // reset mid-operation
    do_reset;
    EVT_RDY = 1'b0; KEY_UP = 4'b0111;
    step;
    KEY_UP = 4'b0100;
    step;
    KEY_UP = 4'b0000;
    step; step;
    chk("t6_smp_ce_c4", 32'(SMP_CE), 1);
    step;
    chk("t6_pre_valid", 32'(EVT_VALID), 1);
    chk("t6_pre_drop", 32'(DROP_CNT), 1);
    CLR = 1'b1;
    #1;
    chk("t6_clr_valid", 32'(EVT_VALID), 0);
    chk("t6_clr_drop", 32'(DROP_CNT), 0);
    chk("t6_clr_smp_ce", 32'(SMP_CE), 0);
    step;
    CLR = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step;
      chk($sformatf("t6_smp_ce_c%0d", k), 32'(SMP_CE), (k == 4) ? 1 : 0);
    end
    chk("t6_post_valid", 32'(EVT_VALID), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
